cflog_slice_ctrl: RTL and testbench

Parametrised successor to the two-block CFLog slice monitor. The CFLog ring is split into NUM_BLOCKS equal slices. The block owns the CFLog write pointer and queues each completed slice for transmission. It offers completed slices to the TCB sender over a req/ack handshake and tracks slices awaiting verifier response. It stalls the logger when no free slice remains and closes a partial final slice on ER completion. It sits between the CF logger (entry writes) and the TCB flush/attest path.

---
 rtl/cflog_slice_ctrl_if.sv | 32 +++
 rtl/cflog_slice_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cflog_slice_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cflog_slice_ctrl_if.sv
// -----------------------------------------------------------------------------
// cflog_slice_ctrl_if
// Flush handshake between the CFLog slice controller and the TCB sender.
//   flush_req    : a completed slice is waiting at the head of the send queue
//   flush_ack    : sender accepts the head slice (qualified by flush_req)
//   flush_idx    : slice index of the head slice
//   flush_top    : byte offset of the first entry of the head slice
//   flush_bottom : byte offset of the last entry of the head slice
//   flush_last   : head slice is the final, ER-closing slice
// master = slice controller, slave = TCB sender.
// -----------------------------------------------------------------------------
interface cflog_slice_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 2
);
  logic              flush_req;
  logic              flush_ack;
  logic [IDX_W-1:0]  flush_idx;
  logic [ADDR_W-1:0] flush_top;
  logic [ADDR_W-1:0] flush_bottom;
  logic              flush_last;

  modport master (
    output flush_req, flush_idx, flush_top, flush_bottom, flush_last,
    input  flush_ack
  );

  modport slave (
    input  flush_req, flush_idx, flush_top, flush_bottom, flush_last,
    output flush_ack
  );
endinterface

// File: rtl/cflog_slice_ctrl.sv
// -----------------------------------------------------------------------------
// cflog_slice_ctrl
// Owns the CFLog write pointer, splits the ring into NUM_BLOCKS equal slices,
// queues each completed slice for the TCB sender and tracks slices that were
// sent but not yet released by the verifier. Stalls the logger when every
// slice is in flight and closes a partial final slice when ER completes.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   log_wr_i     : logger writes one entry at log_ptr_o this cycle
//   log_ptr_o    : byte offset of the next entry
//   hold_o       : no free slice, logger must stall
//   er_done_i    : ER finished (level or pulse, latched internally)
//   vrf_ack_i    : verifier released the oldest sent slice
//   done_o       : final slice has been sent (sticky)
//   overflow_o   : a write was dropped while stalled or finished (sticky)
//   flush_if     : flush handshake to the TCB sender (master side)
// -----------------------------------------------------------------------------
module cflog_slice_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned LOG_SIZE    = 16'h0100,
  parameter int unsigned NUM_BLOCKS  = 4,
  parameter int unsigned ENTRY_BYTES = 2,
  parameter int unsigned BLOCK_SIZE  = LOG_SIZE / NUM_BLOCKS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               log_wr_i,
  output logic [ADDR_W-1:0]  log_ptr_o,
  output logic               hold_o,
  input  logic               er_done_i,
  input  logic               vrf_ack_i,
  output logic               done_o,
  output logic               overflow_o,
  cflog_slice_ctrl_if.master flush_if
);

  localparam int unsigned IDX_W   = $clog2(NUM_BLOCKS);
  localparam int unsigned CNT_W   = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned ENTRIES = BLOCK_SIZE / ENTRY_BYTES;
  localparam int unsigned FILL_W  = $clog2(ENTRIES + 1);

  localparam logic [ADDR_W-1:0] BLK_SZ       = ADDR_W'(BLOCK_SIZE);
  localparam logic [ADDR_W-1:0] EB           = ADDR_W'(ENTRY_BYTES);
  localparam logic [ADDR_W-1:0] LAST_OFF     = ADDR_W'(LOG_SIZE - ENTRY_BYTES);
  localparam logic [ADDR_W-1:0] BLK_LAST_OFF = ADDR_W'(BLOCK_SIZE - ENTRY_BYTES);
  localparam logic [CNT_W-1:0]  NUM_CNT      = CNT_W'(NUM_BLOCKS);

  // Registered state
  logic [ADDR_W-1:0] log_ptr_q,      log_ptr_d;
  logic [IDX_W-1:0]  wr_blk_q,       wr_blk_d;
  logic [FILL_W-1:0] fill_q,         fill_d;
  logic [IDX_W-1:0]  send_blk_q,     send_blk_d;
  logic [CNT_W-1:0]  send_cnt_q,     send_cnt_d;
  logic [CNT_W-1:0]  outstanding_q,  outstanding_d;
  logic              fin_q,          fin_d;
  logic              final_queued_q, final_queued_d;
  logic [ADDR_W-1:0] final_bottom_q, final_bottom_d;
  logic              done_q,         done_d;
  logic              overflow_q,     overflow_d;

  // Event decode
  logic              hold;
  logic              accept;
  logic              complete;
  logic              finish;
  logic [FILL_W-1:0] fill_post;
  logic              partial;
  logic              q_inc;
  logic              send_dec;
  logic              vrf_dec;
  logic [ADDR_W-1:0] wr_blk_last;
  logic [ADDR_W-1:0] head_top;
  logic              head_last;

  assign hold        = (outstanding_q == NUM_CNT);
  assign accept      = log_wr_i && !hold && !fin_q;
  assign wr_blk_last = ADDR_W'(wr_blk_q) * BLK_SZ + BLK_LAST_OFF;
  assign complete    = accept && (log_ptr_q == wr_blk_last);
  assign finish      = er_done_i && !fin_q;

  // Fill level after this cycle's write; a write coinciding with er_done is
  // counted before deciding whether a partial slice must be closed.
  assign fill_post = complete ? '0 : (accept ? fill_q + FILL_W'(1) : fill_q);
  assign partial   = finish && (fill_post != '0);
  assign q_inc     = complete || partial;

  assign send_dec  = flush_if.flush_ack && flush_if.flush_req;
  // Only slices already handed to the sender can be released; counts are
  // taken before this edge so a same-cycle flush_ack does not qualify.
  assign vrf_dec   = vrf_ack_i && (outstanding_q > send_cnt_q);

  assign head_top  = ADDR_W'(send_blk_q) * BLK_SZ;
  assign head_last = fin_q && final_queued_q && (send_cnt_q == CNT_W'(1));

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    log_ptr_d      = log_ptr_q;
    wr_blk_d       = wr_blk_q;
    fill_d         = fill_post;
    send_blk_d     = send_blk_q;
    send_cnt_d     = send_cnt_q + CNT_W'(q_inc) - CNT_W'(send_dec);
    outstanding_d  = outstanding_q + CNT_W'(q_inc) - CNT_W'(vrf_dec);
    fin_d          = fin_q;
    final_queued_d = final_queued_q;
    final_bottom_d = final_bottom_q;
    overflow_d     = overflow_q;

    if (accept) begin
      log_ptr_d = (log_ptr_q == LAST_OFF) ? '0 : log_ptr_q + EB;
    end

    if (log_wr_i && !accept) begin
      overflow_d = 1'b1;
    end

    if (q_inc) begin
      wr_blk_d = wr_blk_q + IDX_W'(1);
      fill_d   = '0;
    end

    if (finish) begin
      fin_d          = 1'b1;
      final_queued_d = q_inc;
      // Last entry of the closing slice: the entry written this cycle if any,
      // otherwise the one just below the write pointer.
      final_bottom_d = accept ? log_ptr_q : log_ptr_q - EB;
    end

    if (send_dec) begin
      send_blk_d = send_blk_q + IDX_W'(1);
    end

    // fin never clears and send_cnt cannot grow after fin, so this is sticky.
    done_d = done_q || (fin_d && (send_cnt_d == '0));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      log_ptr_q      <= '0;
      wr_blk_q       <= '0;
      fill_q         <= '0;
      send_blk_q     <= '0;
      send_cnt_q     <= '0;
      outstanding_q  <= '0;
      fin_q          <= 1'b0;
      final_queued_q <= 1'b0;
      final_bottom_q <= '0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      log_ptr_q      <= log_ptr_d;
      wr_blk_q       <= wr_blk_d;
      fill_q         <= fill_d;
      send_blk_q     <= send_blk_d;
      send_cnt_q     <= send_cnt_d;
      outstanding_q  <= outstanding_d;
      fin_q          <= fin_d;
      final_queued_q <= final_queued_d;
      final_bottom_q <= final_bottom_d;
      done_q         <= done_d;
      overflow_q     <= overflow_d;
    end
  end

  assign log_ptr_o  = log_ptr_q;
  assign hold_o     = hold;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

  assign flush_if.flush_req    = (send_cnt_q != '0);
  assign flush_if.flush_idx    = send_blk_q;
  assign flush_if.flush_top    = head_top;
  assign flush_if.flush_bottom = head_last ? final_bottom_q : head_top + BLK_LAST_OFF;
  assign flush_if.flush_last   = head_last;

endmodule

// File: tb/tb_cflog_slice_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cflog_slice_ctrl
// Self-checking bench for cflog_slice_ctrl with LOG_SIZE=0x40, NUM_BLOCKS=4
// (16-byte slices, 8 two-byte entries each). Expected flush records are queued
// when the slice-closing stimulus is driven and compared when the sender acks.
// -----------------------------------------------------------------------------
module tb_cflog_slice_ctrl;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IDX_W  = 2;

  typedef struct {
    logic        wr;
    logic        er;
    logic        ack;
    logic        vrf;
    logic [15:0] ptr;
    logic        hold;
    logic        req;
    logic        ovf;
    logic        done;
  } vec_t;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] top;
    logic [15:0] bottom;
    logic        last;
  } slice_t;

  logic              clk;
  logic              reset;
  logic              log_wr;
  logic [ADDR_W-1:0] log_ptr;
  logic              hold;
  logic              er_done;
  logic              vrf_ack;
  logic              done;
  logic              overflow;

  cflog_slice_ctrl_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) fif ();

  cflog_slice_ctrl #(
    .ADDR_W     (ADDR_W),
    .LOG_SIZE   (16'h0040),
    .NUM_BLOCKS (4),
    .ENTRY_BYTES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .log_wr_i   (log_wr),
    .log_ptr_o  (log_ptr),
    .hold_o     (hold),
    .er_done_i  (er_done),
    .vrf_ack_i  (vrf_ack),
    .done_o     (done),
    .overflow_o (overflow),
    .flush_if   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  slice_t sb[$];
  vec_t   tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [1:0] idx, input logic [15:0] top,
                         input logic [15:0] bottom, input logic last);
    slice_t s;
    s.idx = idx; s.top = top; s.bottom = bottom; s.last = last;
    sb.push_back(s);
  endtask

  // Compare the head slice the DUT presents against the oldest expectation.
  task automatic sb_pop_check(input string tag);
    slice_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_req"},    32'(fif.flush_req),    32'd1);
      check({tag, "_idx"},    32'(fif.flush_idx),    32'(e.idx));
      check({tag, "_top"},    32'(fif.flush_top),    32'(e.top));
      check({tag, "_bottom"}, 32'(fif.flush_bottom), 32'(e.bottom));
      check({tag, "_last"},   32'(fif.flush_last),   32'(e.last));
    end
  endtask

  task automatic do_ack(input string tag);
    sb_pop_check(tag);
    fif.flush_ack = 1'b1;
    step();
    fif.flush_ack = 1'b0;
  endtask

  task automatic do_writes(input int n);
    log_wr = 1'b1;
    repeat (n) step();
    log_wr = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    log_wr = 1'b0; er_done = 1'b0; vrf_ack = 1'b0; fif.flush_ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check({tag, "_ptr"},  32'(log_ptr),       32'h0);
    check({tag, "_hold"}, 32'(hold),          32'h0);
    check({tag, "_req"},  32'(fif.flush_req), 32'h0);
    check({tag, "_top"},  32'(fif.flush_top), 32'h0);
    check({tag, "_idx"},  32'(fif.flush_idx), 32'h0);
    check({tag, "_last"}, 32'(fif.flush_last), 32'h0);
    check({tag, "_done"}, 32'(done),          32'h0);
    check({tag, "_ovf"},  32'(overflow),      32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Table: fill slice 0, ack it, stray vrf_ack, finish with empty slice,
    // then a write after finish must be dropped.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{wr: 1'b1, er: 1'b0, ack: 1'b0, vrf: 1'b0, ptr: 16'(2 * (i + 1)),
                 hold: 1'b0, req: (i == 7), ovf: 1'b0, done: 1'b0};
    end
    tbl[8]  = '{wr: 1'b0, er: 1'b0, ack: 1'b1, vrf: 1'b0, ptr: 16'h0010,
                hold: 1'b0, req: 1'b0, ovf: 1'b0, done: 1'b0};
    tbl[9]  = '{wr: 1'b0, er: 1'b0, ack: 1'b0, vrf: 1'b1, ptr: 16'h0010,
                hold: 1'b0, req: 1'b0, ovf: 1'b0, done: 1'b0};
    tbl[10] = '{wr: 1'b0, er: 1'b1, ack: 1'b0, vrf: 1'b0, ptr: 16'h0010,
                hold: 1'b0, req: 1'b0, ovf: 1'b0, done: 1'b1};
    tbl[11] = '{wr: 1'b1, er: 1'b0, ack: 1'b0, vrf: 1'b0, ptr: 16'h0010,
                hold: 1'b0, req: 1'b0, ovf: 1'b1, done: 1'b1};

    reset = 1'b1;
    log_wr = 1'b0; er_done = 1'b0; vrf_ack = 1'b0; fif.flush_ack = 1'b0;
    do_reset("rst0");

    // ---- Table-driven: first slice fill and flush ----
    sb_push(2'd0, 16'h0000, 16'h000E, 1'b0);
    for (int i = 0; i < 12; i++) begin
      log_wr = tbl[i].wr; er_done = tbl[i].er; vrf_ack = tbl[i].vrf;
      fif.flush_ack = tbl[i].ack;
      if (tbl[i].ack) sb_pop_check($sformatf("row%0d_flush", i));
      step();
      check($sformatf("row%0d_ptr", i),  32'(log_ptr),       32'(tbl[i].ptr));
      check($sformatf("row%0d_hold", i), 32'(hold),          32'(tbl[i].hold));
      check($sformatf("row%0d_req", i),  32'(fif.flush_req), 32'(tbl[i].req));
      check($sformatf("row%0d_ovf", i),  32'(overflow),      32'(tbl[i].ovf));
      check($sformatf("row%0d_done", i), 32'(done),          32'(tbl[i].done));
    end
    log_wr = 1'b0; er_done = 1'b0; vrf_ack = 1'b0; fif.flush_ack = 1'b0;

    // ---- Backpressure: fill all four slices without acks ----
    do_reset("rst1");
    for (int i = 0; i < 4; i++) sb_push(2'(i), 16'(16 * i), 16'(16 * i + 14), 1'b0);
    do_writes(31);
    check("bp31_ptr",  32'(log_ptr), 32'h3E);
    check("bp31_hold", 32'(hold),    32'h0);
    do_writes(1);
    check("bp32_ptr",  32'(log_ptr), 32'h00);
    check("bp32_hold", 32'(hold),    32'h1);
    check("bp32_ovf",  32'(overflow), 32'h0);
    do_writes(1);
    check("bp33_ovf",  32'(overflow), 32'h1);
    check("bp33_ptr",  32'(log_ptr),  32'h00);

    // vrf_ack before anything was sent must be ignored.
    vrf_ack = 1'b1; step(); vrf_ack = 1'b0;
    check("early_vrf_hold", 32'(hold), 32'h1);

    // ---- Release order: three acks, then ack + vrf_ack together ----
    do_ack("rel0");
    do_ack("rel1");
    do_ack("rel2");
    check("rel2_hold", 32'(hold), 32'h1);
    vrf_ack = 1'b1;
    do_ack("rel3");
    vrf_ack = 1'b0;
    check("rel3_req",  32'(fif.flush_req), 32'h0);
    check("rel3_hold", 32'(hold),          32'h0);
    do_writes(1);
    check("rel_wr_ptr", 32'(log_ptr),  32'h02);
    check("rel_ovf",    32'(overflow), 32'h1);

    // ---- Partial finish ----
    do_reset("rst2");
    do_writes(3);
    check("part_ptr", 32'(log_ptr), 32'h06);
    sb_push(2'd0, 16'h0000, 16'h0004, 1'b1);
    er_done = 1'b1; step(); er_done = 1'b0;
    check("part_req",  32'(fif.flush_req),  32'h1);
    check("part_last", 32'(fif.flush_last), 32'h1);
    check("part_done", 32'(done),           32'h0);
    do_writes(1);
    check("part_ovf", 32'(overflow), 32'h1);
    check("part_ptr_hold", 32'(log_ptr), 32'h06);
    do_ack("part");
    check("part_done_ack", 32'(done),          32'h1);
    check("part_req_ack",  32'(fif.flush_req), 32'h0);

    // ---- Exact-boundary finish: 8th write with er_done ----
    do_reset("rst3");
    do_writes(7);
    sb_push(2'd0, 16'h0000, 16'h000E, 1'b1);
    log_wr = 1'b1; er_done = 1'b1; step(); log_wr = 1'b0; er_done = 1'b0;
    check("edge_ptr",  32'(log_ptr),        32'h10);
    check("edge_req",  32'(fif.flush_req),  32'h1);
    check("edge_last", 32'(fif.flush_last), 32'h1);
    do_ack("edge");
    check("edge_req_after", 32'(fif.flush_req), 32'h0);
    check("edge_done",      32'(done),          32'h1);

    // ---- Reset while flush_req is pending ----
    do_reset("rst4");
    do_writes(8);
    er_done = 1'b1; step(); er_done = 1'b0;
    do_writes(1);
    check("mid_req", 32'(fif.flush_req), 32'h1);
    check("mid_ovf", 32'(overflow),      32'h1);
    do_reset("mid_rst");
    step();
    check("mid_req_idle", 32'(fif.flush_req), 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
